// File: rtl/div_err_pkg.sv
// rtl/div_err_pkg.sv - shared types, default widths and saturating add for the divider error accumulator
package div_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_CNT_W = 25;
  localparam int unsigned DEF_SUM_W = 32;

  // Add an 8-bit increment to an accumulator of 'width' bits, clamping at all-ones (width < 64)
  function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [7:0] inc,
                                          input int unsigned width);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (64'd1 << width) - 64'd1;
    sum = acc + {56'd0, inc};
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/div_abs_err.sv
// rtl/div_abs_err.sv - combinational |q_apx-q_ex| and quotient/remainder mismatch flag
module div_abs_err (
  input  logic [7:0] q_apx_i,
  input  logic [7:0] q_ex_i,
  input  logic [7:0] r_apx_i,
  input  logic [7:0] r_ex_i,
  output logic [7:0] ae_o,
  output logic       mism_o
);

  logic [8:0] diff;
  logic [8:0] neg;

  // 9-bit signed difference; its magnitude always fits in 8 bits
  always_comb begin
    diff   = {1'b0, q_apx_i} - {1'b0, q_ex_i};
    neg    = 9'd0 - diff;
    ae_o   = diff[8] ? neg[7:0] : diff[7:0];
    mism_o = (q_apx_i != q_ex_i) || (r_apx_i != r_ex_i);
  end

endmodule

// File: rtl/div_error_accumulator.sv
// rtl/div_error_accumulator.sv - measures approximate-divider error over a programmed sample count
module div_error_accumulator
  import div_err_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       d,
  input  logic [7:0]       q_apx,
  input  logic [7:0]       r_apx,
  input  logic [7:0]       q_ex,
  input  logic [7:0]       r_ex,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] n_samples,
  output logic [CNT_W-1:0] n_mismatch,
  output logic [CNT_W-1:0] n_div0,
  output logic [SUM_W-1:0] err_sum,
  output logic [7:0]       err_max
);

  state_e           state_q;
  logic             in_ready_q, busy_q, done_q;
  logic [CNT_W-1:0] target_q, acc_cnt_q, acc_cnt_inc;

  logic             s1_valid_q, s1_div0_q, s1_mism_q;
  logic [7:0]       s1_ae_q;

  logic [CNT_W-1:0] n_samples_q, n_samples_d;
  logic [CNT_W-1:0] n_mismatch_q, n_mismatch_d;
  logic [CNT_W-1:0] n_div0_q, n_div0_d;
  logic [SUM_W-1:0] err_sum_q, err_sum_d;
  logic [7:0]       err_max_q, err_max_d;

  logic             accept, start_clr, mism_c;
  logic [7:0]       ae_c;

  assign accept      = in_valid & in_ready_q;
  assign start_clr   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign acc_cnt_inc = acc_cnt_q + 1'b1;

  div_abs_err u_abs_err (
    .q_apx_i (q_apx),
    .q_ex_i  (q_ex),
    .r_apx_i (r_apx),
    .r_ex_i  (r_ex),
    .ae_o    (ae_c),
    .mism_o  (mism_c)
  );

  // Run control: start latches target, final accept drains, drain completes when stage 1 is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      target_q   <= '0;
      acc_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            target_q  <= target;
            acc_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            if (target == '0) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= ST_RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_inc;
            if (acc_cnt_inc == target_q) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!s1_valid_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture per-sample classification and absolute error on each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_div0_q  <= 1'b0;
      s1_mism_q  <= 1'b0;
      s1_ae_q    <= '0;
    end else if (start_clr) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_div0_q <= (d == 8'd0);
        s1_mism_q <= mism_c;
        s1_ae_q   <= ae_c;
      end
    end
  end

  // Stage 2 next state: divide-by-zero samples only bump their own counter
  always_comb begin
    n_samples_d  = n_samples_q;
    n_mismatch_d = n_mismatch_q;
    n_div0_d     = n_div0_q;
    err_sum_d    = err_sum_q;
    err_max_d    = err_max_q;
    if (start_clr) begin
      n_samples_d  = '0;
      n_mismatch_d = '0;
      n_div0_d     = '0;
      err_sum_d    = '0;
      err_max_d    = '0;
    end else if (s1_valid_q) begin
      n_samples_d = n_samples_q + 1'b1;
      if (s1_div0_q) begin
        n_div0_d = n_div0_q + 1'b1;
      end else begin
        n_mismatch_d = n_mismatch_q + CNT_W'(s1_mism_q);
        err_max_d    = (s1_ae_q > err_max_q) ? s1_ae_q : err_max_q;
        err_sum_d    = SUM_W'(sat_add(64'(err_sum_q), s1_ae_q, SUM_W));
      end
    end
  end

  // Stage 2 registers: accumulated results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_samples_q  <= '0;
      n_mismatch_q <= '0;
      n_div0_q     <= '0;
      err_sum_q    <= '0;
      err_max_q    <= '0;
    end else begin
      n_samples_q  <= n_samples_d;
      n_mismatch_q <= n_mismatch_d;
      n_div0_q     <= n_div0_d;
      err_sum_q    <= err_sum_d;
      err_max_q    <= err_max_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign n_samples  = n_samples_q;
  assign n_mismatch = n_mismatch_q;
  assign n_div0     = n_div0_q;
  assign err_sum    = err_sum_q;
  assign err_max    = err_max_q;

endmodule

// File: tb/tb_div_error_accumulator.sv
// tb/tb_div_error_accumulator.sv - directed self-checking bench for div_error_accumulator
module tb_div_error_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [24:0] target = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  d = '0, q_apx = '0, r_apx = '0, q_ex = '0, r_ex = '0;

  logic        in_ready, busy, done;
  logic [24:0] n_samples, n_mismatch, n_div0;
  logic [31:0] err_sum;
  logic [7:0]  err_max;

  logic        in_ready8, busy8, done8;
  logic [24:0] n_samples8, n_mismatch8, n_div08;
  logic [7:0]  err_sum8;
  logic [7:0]  err_max8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_error_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .q_apx(q_apx), .r_apx(r_apx), .q_ex(q_ex), .r_ex(r_ex),
    .busy(busy), .done(done), .n_samples(n_samples), .n_mismatch(n_mismatch),
    .n_div0(n_div0), .err_sum(err_sum), .err_max(err_max)
  );

  div_error_accumulator #(.CNT_W(25), .SUM_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .in_valid(in_valid), .in_ready(in_ready8), .d(d),
    .q_apx(q_apx), .r_apx(r_apx), .q_ex(q_ex), .r_ex(r_ex),
    .busy(busy8), .done(done8), .n_samples(n_samples8), .n_mismatch(n_mismatch8),
    .n_div0(n_div08), .err_sum(err_sum8), .err_max(err_max8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [24:0] t);
    start  = 1'b1;
    target = t;
    tick();
    start  = 1'b0;
  endtask

  task automatic send(input logic [7:0] dv, input logic [7:0] qa, input logic [7:0] qe,
                      input logic [7:0] ra, input logic [7:0] re);
    in_valid = 1'b1;
    d = dv; q_apx = qa; q_ex = qe; r_apx = ra; r_ex = re;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b required 1", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {in_ready, busy, done});
    end
    checks++;
    if (n_samples !== 0 || n_mismatch !== 0 || n_div0 !== 0 || err_sum !== 0 || err_max !== 0) begin
      errors++;
      $display("FAIL reset_counts: got %0d %0d %0d %0d %0d required all 0",
               n_samples, n_mismatch, n_div0, err_sum, err_max);
    end
  endtask

  task automatic test_exact_back_to_back();
    in_valid = 1'b1;
    d = 8'd3; q_apx = 8'd100; q_ex = 8'd0; r_apx = 8'd1; r_ex = 8'd1;
    do_start(25'd4);
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL exact_after_start: got %b required 110", {in_ready, busy, done});
    end
    for (int i = 0; i < 4; i++) send(8'd3, 8'd5, 8'd5, 8'd1, 8'd1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL exact_ready_drop: got %b required 0", in_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL exact_done_early: got %b required 0", done);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL exact_done_edge: got busy,done=%b required 01", {busy, done});
    end
    checks++;
    if (n_samples !== 4 || n_mismatch !== 0 || err_sum !== 0 || err_max !== 0 || n_div0 !== 0) begin
      errors++;
      $display("FAIL exact_results: got n=%0d mm=%0d sum=%0d max=%0d dz=%0d required 4 0 0 0 0",
               n_samples, n_mismatch, err_sum, err_max, n_div0);
    end
  endtask

  task automatic test_errors();
    do_start(25'd3);
    send(8'd5, 8'd10, 8'd7, 8'd2, 8'd2);
    send(8'd5, 8'd2, 8'd9, 8'd2, 8'd2);
    send(8'd5, 8'd255, 8'd0, 8'd2, 8'd2);
    wait_done("errors");
    checks++;
    if (err_sum !== 265 || err_max !== 255 || n_mismatch !== 3 || n_samples !== 3) begin
      errors++;
      $display("FAIL errors_results: got sum=%0d max=%0d mm=%0d n=%0d required 265 255 3 3",
               err_sum, err_max, n_mismatch, n_samples);
    end
    checks++;
    if (err_sum8 !== 8'd255) begin
      errors++;
      $display("FAIL errors_sum8_sat: got %0d required 255", err_sum8);
    end
  endtask

  task automatic test_div0();
    do_start(25'd2);
    send(8'd0, 8'd255, 8'd0, 8'd0, 8'd0);
    send(8'd4, 8'd6, 8'd6, 8'd3, 8'd3);
    wait_done("div0");
    checks++;
    if (n_div0 !== 1 || err_sum !== 0 || n_mismatch !== 0 || n_samples !== 2 || err_max !== 0) begin
      errors++;
      $display("FAIL div0_results: got dz=%0d sum=%0d mm=%0d n=%0d max=%0d required 1 0 0 2 0",
               n_div0, err_sum, n_mismatch, n_samples, err_max);
    end
  endtask

  task automatic test_zero_target();
    do_start(25'd0);
    checks++;
    if ({in_ready, busy, done} !== 3'b010) begin
      errors++;
      $display("FAIL zero_drain: got %b required 010", {in_ready, busy, done});
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b01 || n_samples !== 0 || n_div0 !== 0 || err_sum !== 0) begin
      errors++;
      $display("FAIL zero_done: got busy,done=%b n=%0d dz=%0d sum=%0d required 01 0 0 0",
               {busy, done}, n_samples, n_div0, err_sum);
    end
    do_start(25'd1);
    checks++;
    if ({in_ready, done} !== 2'b10) begin
      errors++;
      $display("FAIL fresh_start: got ready,done=%b required 10", {in_ready, done});
    end
    send(8'd2, 8'd4, 8'd1, 8'd0, 8'd1);
    wait_done("fresh");
    checks++;
    if (n_samples !== 1 || err_sum !== 3 || err_max !== 3 || n_mismatch !== 1 || n_div0 !== 0) begin
      errors++;
      $display("FAIL fresh_results: got n=%0d sum=%0d max=%0d mm=%0d dz=%0d required 1 3 3 1 0",
               n_samples, err_sum, err_max, n_mismatch, n_div0);
    end
  endtask

  task automatic test_saturate();
    do_start(25'd3);
    for (int i = 0; i < 3; i++) send(8'd7, 8'd200, 8'd0, 8'd1, 8'd1);
    wait_done("sat");
    checks++;
    if (err_sum8 !== 8'd255 || err_max8 !== 8'd200) begin
      errors++;
      $display("FAIL sat_sum8: got sum=%0d max=%0d required 255 200", err_sum8, err_max8);
    end
    checks++;
    if (err_sum !== 600 || err_max !== 200) begin
      errors++;
      $display("FAIL sat_sum32: got sum=%0d max=%0d required 600 200", err_sum, err_max);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(25'd10);
    send(8'd1, 8'd3, 8'd3, 8'd0, 8'd0);
    send(8'd1, 8'd3, 8'd3, 8'd0, 8'd0);
    start  = 1'b1;
    target = 25'd3;
    send(8'd1, 8'd3, 8'd3, 8'd0, 8'd0);
    start  = 1'b0;
    send(8'd1, 8'd3, 8'd3, 8'd0, 8'd0);
    send(8'd1, 8'd3, 8'd3, 8'd0, 8'd0);
    checks++;
    if ({in_ready, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL midrun_start_ignored: got %b required 110", {in_ready, busy, done});
    end
    checks++;
    if (n_samples !== 4) begin
      errors++;
      $display("FAIL midrun_count: got %0d required 4", n_samples);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, busy} !== 2'b00 || n_samples !== 0) begin
      errors++;
      $display("FAIL midrun_async_reset: got ready,busy=%b n=%0d required 00 0", {in_ready, busy}, n_samples);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, busy, done} !== 3'b000 || n_samples !== 0 || n_mismatch !== 0 ||
        err_sum !== 0 || err_max !== 0 || n_div0 !== 0) begin
      errors++;
      $display("FAIL midrun_after_reset: got flags=%b n=%0d mm=%0d sum=%0d max=%0d dz=%0d required all 0",
               {in_ready, busy, done}, n_samples, n_mismatch, err_sum, err_max, n_div0);
    end
  endtask

  initial begin
    test_reset();
    test_exact_back_to_back();
    test_errors();
    test_div0();
    test_zero_target();
    test_saturate();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
